// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set definitions used by fetch, instruction memory and decode.
// Holds the opcode values, the instruction field positions and a few
// helper functions that pull fields out of a 16-bit instruction word.
package fetch_unit_pkg;

  localparam int INSN_W = 16;
  localparam int PC_W   = 8;

  // Field positions inside an instruction word
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int TGT_HI = 11;
  localparam int TGT_LO = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LI   = 4'h1,
    OP_ADDI = 4'h2,
    OP_JNZ  = 4'h3,
    OP_JMP  = 4'h4
  } opcode_e;

  function automatic logic [3:0] insn_opc(input logic [INSN_W-1:0] insn);
    return insn[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [PC_W-1:0] insn_tgt(input logic [INSN_W-1:0] insn);
    return insn[TGT_HI:TGT_LO];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Drives pc to instruction memory, captures the returned word into ir and
// offers it to execute with a valid/ready handshake. Unconditional JMPs are
// resolved here and never reach execute; taken JNZs come back as redirects.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   pc                     fetch address (registered)
//   op                     instruction word for pc (combinational from imem)
//   ir, ir_pc, ir_valid    instruction offered to execute, its address, valid
//   ir_ready               execute accepts ir
//   redirect, redirect_pc  taken-branch redirect from execute
//   halt_req, halted       stop fetching / fetch is stopped
//   jmp_count              number of JMPs resolved locally
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pc,
  input  logic [15:0] op,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic [15:0] jmp_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [15:0] ir_q;
  logic [7:0]  ir_pc_q;
  logic        ir_valid_q;
  logic [15:0] jmp_cnt_q;

  logic load;
  logic accept;
  logic is_jmp;

  assign accept = ir_valid_q && ir_ready;
  // A halt request blocks the load in the same cycle it arrives.
  assign load   = (state_q == RUN) && !halt_req && (!ir_valid_q || ir_ready) && !redirect;
  assign is_jmp = (insn_opc(op) == OP_JMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= PC_RESET;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 8'h00;
      ir_valid_q <= 1'b0;
      jmp_cnt_q  <= 16'h0000;
    end else begin
      if (state_q == RUN && halt_req)
        state_q <= HALT;

      if (redirect) begin
        // Redirect wins over everything, in either state: flush and retarget.
        pc_q       <= redirect_pc;
        ir_valid_q <= 1'b0;
      end else if (load) begin
        if (is_jmp) begin
          pc_q       <= insn_tgt(op);
          ir_valid_q <= 1'b0;
          jmp_cnt_q  <= jmp_cnt_q + 16'd1;
        end else begin
          ir_q       <= op;
          ir_pc_q    <= pc_q;
          ir_valid_q <= 1'b1;
          pc_q       <= pc_q + 8'd1;
        end
      end else if (accept) begin
        // Halting (or halt requested): drain the pending instruction only.
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == HALT);
  assign jmp_count = jmp_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc;
  logic [15:0] op;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        halted;
  logic [15:0] jmp_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [256];
  assign op = mem[pc];

  always #5 clk = ~clk;

  fetch_unit #(.PC_RESET(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .op(op), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted),
    .jmp_count(jmp_count)
  );

  typedef struct {
    logic       rdy;
    logic       rd;
    logic [7:0] rd_pc;
    logic       hreq;
    logic [7:0] e_pc;
    logic       e_v;
    logic [7:0] e_irpc;
    logic       e_halt;
    logic [15:0] e_jmp;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full state check; ir and ir_pc only matter while ir_valid is expected.
  task automatic chk_state(input string tag, input logic [7:0] e_pc, input logic e_v,
                           input logic [7:0] e_irpc, input logic e_halt, input logic [15:0] e_jmp);
    chk({tag, ".pc"}, {24'h0, pc}, {24'h0, e_pc});
    chk({tag, ".ir_valid"}, {31'h0, ir_valid}, {31'h0, e_v});
    if (e_v) begin
      chk({tag, ".ir_pc"}, {24'h0, ir_pc}, {24'h0, e_irpc});
      chk({tag, ".ir"}, {16'h0, ir}, {16'h0, OP_LI, e_irpc, 4'h0});
    end
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, e_halt});
    chk({tag, ".jmp_count"}, {16'h0, jmp_count}, {16'h0, e_jmp});
  endtask

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [7:0] rd_pc,
                              input logic hreq, input logic [7:0] e_pc, input logic e_v,
                              input logic [7:0] e_irpc, input logic e_halt, input logic [15:0] e_jmp);
    vec_t v;
    v.rdy = rdy; v.rd = rd; v.rd_pc = rd_pc; v.hreq = hreq;
    v.e_pc = e_pc; v.e_v = e_v; v.e_irpc = e_irpc; v.e_halt = e_halt; v.e_jmp = e_jmp;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {OP_LI, i[7:0], 4'h0};
    mem[23] = {OP_JMP, 8'd0, 4'h0};

    //              rdy rd  rd_pc  hreq  pc     v  irpc   halt jmp
    vecs[0]  = mk(1, 0, 8'd0,   0, 8'd1,   1, 8'd0,   0, 16'd0); // sequential fetch
    vecs[1]  = mk(1, 0, 8'd0,   0, 8'd2,   1, 8'd1,   0, 16'd0);
    vecs[2]  = mk(1, 0, 8'd0,   0, 8'd3,   1, 8'd2,   0, 16'd0);
    vecs[3]  = mk(1, 0, 8'd0,   0, 8'd4,   1, 8'd3,   0, 16'd0);
    vecs[4]  = mk(1, 0, 8'd0,   0, 8'd5,   1, 8'd4,   0, 16'd0);
    vecs[5]  = mk(1, 0, 8'd0,   0, 8'd6,   1, 8'd5,   0, 16'd0);
    vecs[6]  = mk(0, 0, 8'd0,   0, 8'd6,   1, 8'd5,   0, 16'd0); // stall x3
    vecs[7]  = mk(0, 0, 8'd0,   0, 8'd6,   1, 8'd5,   0, 16'd0);
    vecs[8]  = mk(0, 0, 8'd0,   0, 8'd6,   1, 8'd5,   0, 16'd0);
    vecs[9]  = mk(1, 0, 8'd0,   0, 8'd7,   1, 8'd6,   0, 16'd0); // release
    vecs[10] = mk(0, 1, 8'd37,  0, 8'd37,  0, 8'd0,   0, 16'd0); // redirect during stall
    vecs[11] = mk(1, 0, 8'd0,   0, 8'd38,  1, 8'd37,  0, 16'd0);
    vecs[12] = mk(1, 1, 8'd22,  0, 8'd22,  0, 8'd0,   0, 16'd0); // redirect, ready high
    vecs[13] = mk(1, 0, 8'd0,   0, 8'd23,  1, 8'd22,  0, 16'd0);
    vecs[14] = mk(1, 0, 8'd0,   0, 8'd0,   0, 8'd0,   0, 16'd1); // JMP at 23 -> bubble
    vecs[15] = mk(1, 0, 8'd0,   0, 8'd1,   1, 8'd0,   0, 16'd1);
    vecs[16] = mk(1, 1, 8'hFF,  0, 8'hFF,  0, 8'd0,   0, 16'd1);
    vecs[17] = mk(1, 0, 8'd0,   0, 8'h00,  1, 8'hFF,  0, 16'd1); // pc wraps
    vecs[18] = mk(1, 0, 8'd0,   0, 8'h01,  1, 8'h00,  0, 16'd1);
    vecs[19] = mk(0, 0, 8'd0,   1, 8'h01,  1, 8'h00,  1, 16'd1); // halt, ir pending
    vecs[20] = mk(0, 0, 8'd0,   0, 8'h01,  1, 8'h00,  1, 16'd1);
    vecs[21] = mk(1, 0, 8'd0,   0, 8'h01,  0, 8'd0,   1, 16'd1); // accepted, no new load
    vecs[22] = mk(1, 0, 8'd0,   0, 8'h01,  0, 8'd0,   1, 16'd1);
    vecs[23] = mk(1, 1, 8'd50,  0, 8'd50,  0, 8'd0,   1, 16'd1); // redirect in HALT
    vecs[24] = mk(1, 0, 8'd0,   0, 8'd50,  0, 8'd0,   1, 16'd1);

    ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'd0; halt_req = 1'b0;
    rst_n = 1'b0;
    #13;
    chk_state("reset", 8'd0, 1'b0, 8'd0, 1'b0, 16'd0);
    chk("reset.ir", {16'h0, ir}, 32'h0);
    chk("reset.ir_pc", {24'h0, ir_pc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 25; k++) begin
      ir_ready = vecs[k].rdy; redirect = vecs[k].rd;
      redirect_pc = vecs[k].rd_pc; halt_req = vecs[k].hreq;
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_v,
                vecs[k].e_irpc, vecs[k].e_halt, vecs[k].e_jmp);
    end

    // Async reset between edges while halted: immediate effect.
    ir_ready = 1'b1; redirect = 1'b0; halt_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 8'd0, 1'b0, 8'd0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("post_rst", 8'd1, 1'b1, 8'd0, 1'b0, 16'd0);

    // Redirect and halt together: both take effect.
    redirect = 1'b1; redirect_pc = 8'd10; halt_req = 1'b1;
    @(posedge clk); #1;
    chk_state("rd_halt", 8'd10, 1'b0, 8'd0, 1'b1, 16'd0);
    redirect = 1'b0; halt_req = 1'b0;
    @(posedge clk); #1;
    chk_state("rd_halt_hold", 8'd10, 1'b0, 8'd0, 1'b1, 16'd0);

    // Stalled instruction flushed by reset; fetch restarts at PC_RESET.
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mem[0] = {OP_JMP, 8'd200, 4'h0};
    @(posedge clk); #1;
    chk_state("rst_jmp", 8'd200, 1'b0, 8'd0, 1'b0, 16'd1);
    @(posedge clk); #1;
    chk_state("rst_jmp_next", 8'd201, 1'b1, 8'd200, 1'b0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 8'd0: program counter value loaded on reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 pc  output  8  fetch address driven to the instruction memory.
REQ-005 op  input  16  instruction word returned combinationally by instruction memory for current pc; [15:12] opcode, [11:4] jump target for JMP/JNZ.
REQ-006 ir  output  16  registered instruction presented to execute.
REQ-007 ir_pc  output  8  address from which ir was fetched.
REQ-008 ir_valid  output  1  ir holds an instruction not yet accepted.
REQ-009 ir_ready  input  1  execute accepts ir this cycle when ir_valid&&ir_ready.
REQ-010 redirect  input  1  execute resolved a taken branch (JNZ) this cycle.
REQ-011 redirect_pc  input  8  target for redirect.
REQ-012 halt_req  input  1  request to stop fetching.
REQ-013 halted  output  1  fetch stopped, no further pc advance.
REQ-014 jmp_count  output  16  number of JMPs resolved locally since reset.

Function
REQ-015 States SHALL be RUN and HALT; RUN after reset.
REQ-016 "Load" condition SHALL be state==RUN && (!ir_valid || ir_ready) && !redirect.
REQ-017 On load with op[15:12] != JMP: ir<=op, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
REQ-018 On load with op[15:12] == JMP: pc<=op[11:4], ir_valid<=0, jmp_count<=jmp_count+1; JMP never reaches ir.
REQ-019 pc increment SHALL wrap 8'hFF -> 8'h00; jmp_count SHALL wrap 16'hFFFF -> 0.
REQ-020 When ir_valid && !ir_ready && !redirect: pc, ir, ir_pc, ir_valid SHALL hold.
REQ-021 redirect SHALL have priority over load and stall: pc<=redirect_pc, ir_valid<=0 (flush) next cycle, regardless of ir_ready or state.
REQ-022 redirect in HALT SHALL update pc but remain in HALT.
REQ-023 halt_req in RUN: next state HALT; the instruction in ir (if valid) SHALL remain offered until accepted; no new load.
REQ-024 HALT -> RUN SHALL occur only on reset.
REQ-025 halted SHALL be 1 exactly when state==HALT.
REQ-026 Throughput: one instruction per cycle while ir_ready=1 and no JMP/redirect; JMP costs one bubble; redirect costs one bubble.
REQ-027 Redirect and halt_req in same cycle: both take effect (pc<=redirect_pc, flush, enter HALT).
REQ-028 pc SHALL be a register output (no combinational path from op or ir_ready to pc).

Reset
REQ-029 rst_n low asynchronously: pc=PC_RESET, ir=16'h0000, ir_pc=8'h00, ir_valid=0, jmp_count=0, state=RUN, halted=0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first fetch after release from PC_RESET.

Structure
REQ-031 Opcode constants (JMP, JNZ, LI, ADDI, ...) and field positions SHALL come from the shared definitions package also used by the instruction memory and decoder; state encoding SHALL be local.
REQ-032 No sub-module required; the jmp_count counter may be an inline register.

Verification
REQ-033 Reset release, imem model with sequential non-JMP ops at 0..3, ir_ready=1 -> ir_pc 0,1,2,3 on four consecutive cycles, ir_valid=1 from cycle 1.
REQ-034 op at pc 23 = JMP to 0 -> no ir with ir_pc=23, one bubble, next ir_pc=0, jmp_count increments by 1.
REQ-035 ir_ready=0 for 3 cycles with ir_pc=5 valid -> pc, ir, ir_pc constant; release -> ir_pc=6 next cycle.
REQ-036 redirect=1, redirect_pc=37 while ir_valid=1, ir_ready=0 -> ir_valid=0 next cycle, following ir_pc=37.
REQ-037 pc=8'hFF, non-JMP op -> next pc=8'h00; halt_req pulse -> halted=1, pending ir stays until accepted, pc frozen.
REQ-038 rst_n asserted asynchronously between edges while halted -> outputs at reset values immediately, RUN after release.
